// File: rtl/mouse_pkg.sv
// Definitions shared by the PS/2 mouse receive and send paths.
package mouse_pkg;

    localparam int BYTE_WIDTH = 8;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mouse_line_sync.sv
// Two-flop synchronizer, debounce filter and filtered falling-edge strobe for one PS/2 line.
module mouse_line_sync
    import mouse_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic sync,
    output logic fall
);

    localparam int CW = cnt_width(FILTER_LEN);
    localparam logic [CW-1:0] RELOAD = CW'(FILTER_LEN - 1);

    logic          meta;
    logic          level;
    logic [CW-1:0] cnt;

    // The filtered level only follows sync after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta  <= 1'b1;
            sync  <= 1'b1;
            level <= 1'b1;
            cnt   <= RELOAD;
            fall  <= 1'b0;
        end else begin
            meta <= line;
            sync <= meta;
            fall <= 1'b0;
            if (sync == level) begin
                cnt <= RELOAD;
            end else if (cnt == '0) begin
                level <= sync;
                cnt   <= RELOAD;
                fall  <= level;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mouse_recv_byte.sv
// PS/2 device-to-host byte receiver: start, LSB-first data, odd parity, stop.
// Optional frame watchdog is compiled in when MOUSE_RECV_TIMEOUT_EN is defined.
//
// state     | meaning
// RX_IDLE   | waiting for a fall with data low (start bit)
// RX_DATA   | shifting in data bits, LSB first
// RX_PARITY | capturing the parity bit
// RX_STOP   | checking stop bit, then report byte or error
module mouse_recv_byte #(
    parameter int BYTE_WIDTH     = mouse_pkg::BYTE_WIDTH,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic                  i_driver_clk,
    input  logic                  rst,
    input  logic                  i_mouse_clk,
    input  logic                  i_mouse_data,
    input  logic                  i_rx_en,
    output logic [BYTE_WIDTH-1:0] o_byte,
    output logic                  o_byte_valid,
    output logic                  o_parity_err,
    output logic                  o_frame_err,
    output logic                  o_timeout,
    output logic                  o_busy
);

    import mouse_pkg::rx_state_t;
    import mouse_pkg::RX_IDLE;
    import mouse_pkg::RX_DATA;
    import mouse_pkg::RX_PARITY;
    import mouse_pkg::RX_STOP;

    localparam int CNT_W = mouse_pkg::cnt_width(BYTE_WIDTH);

    rx_state_t             state, state_next;
    logic [CNT_W-1:0]      bit_cnt, bit_cnt_next;
    logic [BYTE_WIDTH-1:0] shreg, shreg_next;
    logic [BYTE_WIDTH-1:0] byte_next;
    logic                  par_acc, par_next;
    logic                  valid_next, perr_next, ferr_next;
    logic                  clk_fall;
    logic                  data_sync;
    logic                  unused_clk_sync;
    logic                  unused_data_fall;

    mouse_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
        .clk  (i_driver_clk),
        .rst  (rst),
        .line (i_mouse_clk),
        .sync (unused_clk_sync),
        .fall (clk_fall)
    );

    mouse_line_sync #(.FILTER_LEN(FILTER_LEN)) u_data_sync (
        .clk  (i_driver_clk),
        .rst  (rst),
        .line (i_mouse_data),
        .sync (data_sync),
        .fall (unused_data_fall)
    );

`ifdef MOUSE_RECV_TIMEOUT_EN
    localparam int WD_W = mouse_pkg::cnt_width(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_RELOAD = WD_W'(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;
    logic            timeout_next;

    // A fall landing on the expiry cycle still counts as progress.
    assign wd_expire = (state != RX_IDLE) && (wd_cnt == '0) && !clk_fall;

    always_ff @(posedge i_driver_clk or posedge rst) begin
        if (rst) begin
            wd_cnt    <= WD_RELOAD;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= timeout_next;
            if (state == RX_IDLE || clk_fall) begin
                wd_cnt <= WD_RELOAD;
            end else if (wd_cnt != '0) begin
                wd_cnt <= wd_cnt - 1'b1;
            end
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_driver_clk or posedge rst) begin
        if (rst) begin
            state        <= RX_IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_acc      <= 1'b0;
            o_byte       <= '0;
            o_byte_valid <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            state        <= state_next;
            bit_cnt      <= bit_cnt_next;
            shreg        <= shreg_next;
            par_acc      <= par_next;
            o_byte       <= byte_next;
            o_byte_valid <= valid_next;
            o_parity_err <= perr_next;
            o_frame_err  <= ferr_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        par_next     = par_acc;
        byte_next    = o_byte;
        valid_next   = 1'b0;
        perr_next    = 1'b0;
        ferr_next    = 1'b0;
`ifdef MOUSE_RECV_TIMEOUT_EN
        timeout_next = 1'b0;
`endif
        if (state != RX_IDLE && !i_rx_en) begin
            state_next = RX_IDLE;
        end
`ifdef MOUSE_RECV_TIMEOUT_EN
        else if (wd_expire) begin
            state_next   = RX_IDLE;
            timeout_next = 1'b1;
        end
`endif
        else if (clk_fall) begin
            case (state)
                RX_IDLE: begin
                    if (!data_sync && i_rx_en) begin
                        state_next   = RX_DATA;
                        bit_cnt_next = '0;
                        par_next     = 1'b0;
                    end
                end
                RX_DATA: begin
                    shreg_next[bit_cnt] = data_sync;
                    par_next            = par_acc ^ data_sync;
                    bit_cnt_next        = bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(BYTE_WIDTH - 1)) begin
                        state_next = RX_PARITY;
                    end
                end
                RX_PARITY: begin
                    par_next   = par_acc ^ data_sync;
                    state_next = RX_STOP;
                end
                RX_STOP: begin
                    state_next = RX_IDLE;
                    // par_acc holds data ones plus parity bit; odd means good.
                    if (!data_sync) begin
                        ferr_next = 1'b1;
                    end else if (par_acc) begin
                        byte_next  = shreg;
                        valid_next = 1'b1;
                    end else begin
                        perr_next = 1'b1;
                    end
                end
                default: state_next = RX_IDLE;
            endcase
        end
    end

    assign o_busy = (state != RX_IDLE);

endmodule
